noc_link_vc_scheduler: RTL

Per-output-link flit scheduler that shares one physical NoC link between the `CHANNELS` virtual channels of an output port. It sits downstream of the port/VC allocation stage and the per-VC output buffers. It tracks downstream buffer credits per VC, selects at most one flit per cycle by round-robin among eligible VCs, and drives a registered link interface. Packet-lock (wormhole) behaviour is selectable at compile time.

---
 rtl/noc_link_vc_scheduler.sv | 87 ++++++++
 1 files changed

// File: rtl/noc_link_vc_scheduler.sv
// noc_link_vc_scheduler: credit-based round-robin VC link scheduler; define NOC_LINK_PACKET_LOCK_EN for wormhole packet lock
`ifndef Noc_VC_Channel
`define Noc_VC_Channel 2
`endif
module noc_link_vc_scheduler #(
  parameter int CHANNELS     = `Noc_VC_Channel,
  parameter int CREDIT_DEPTH = 4,
  parameter int VC_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CREDIT_W     = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                noc_clk,
  input  logic                noc_rst,
  input  logic [CHANNELS-1:0] flit_valid,
  input  logic [CHANNELS-1:0] flit_tail,
  output logic [CHANNELS-1:0] flit_pop,
  input  logic [CHANNELS-1:0] credit_return,
  output logic [CHANNELS-1:0] vc_ready,
  output logic                link_valid,
  output logic [VC_W-1:0]     link_vc,
  output logic                link_tail,
  output logic                credit_overflow
);
  logic [CREDIT_W-1:0] cred [CHANNELS];
  logic [VC_W-1:0] rr_ptr, win, idx;
  logic [CHANNELS-1:0] eligible, cand, ovf_hit;
  logic grant;
`ifdef NOC_LINK_PACKET_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [VC_W-1:0] lock_vc;
  assign cand = (state == LOCKED) ? eligible & (CHANNELS'(1) << lock_vc) : eligible;
`else
  assign cand = eligible;
`endif
  always_comb begin
    vc_ready = '0;
    ovf_hit = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      vc_ready[v] = cred[v] != '0;
      ovf_hit[v] = credit_return[v] & ~flit_pop[v] & (cred[v] == CREDIT_W'(CREDIT_DEPTH));
    end
  end
  assign eligible = flit_valid & vc_ready;
  // descending scan so the smallest offset from rr_ptr+1 wins
  always_comb begin
    grant = 1'b0;
    win = '0;
    idx = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = VC_W'((int'(rr_ptr) + k) % CHANNELS);
      if (cand[idx]) begin
        grant = 1'b1;
        win = idx;
      end
    end
  end
  assign flit_pop = (grant && !noc_rst) ? CHANNELS'(1) << win : '0;
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      for (int v = 0; v < CHANNELS; v++) cred[v] <= CREDIT_W'(CREDIT_DEPTH);
      rr_ptr <= VC_W'(CHANNELS - 1);
      link_valid <= 1'b0;
      link_vc <= '0;
      link_tail <= 1'b0;
      credit_overflow <= 1'b0;
`ifdef NOC_LINK_PACKET_LOCK_EN
      state <= IDLE;
      lock_vc <= '0;
`endif
    end else begin
      for (int v = 0; v < CHANNELS; v++)
        if (flit_pop[v] && !credit_return[v]) cred[v] <= cred[v] - CREDIT_W'(1);
        else if (credit_return[v] && !flit_pop[v] && !ovf_hit[v]) cred[v] <= cred[v] + CREDIT_W'(1);
      credit_overflow <= credit_overflow | (|ovf_hit);
      link_valid <= grant;
      if (grant) begin
        rr_ptr <= win;
        link_vc <= win;
        link_tail <= flit_tail[win];
`ifdef NOC_LINK_PACKET_LOCK_EN
        state <= flit_tail[win] ? IDLE : LOCKED;
        lock_vc <= win;
`endif
      end
    end
  end
endmodule
